// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: icodes, status codes, the
// fetch->decode bundle and its bubble value, decode helpers.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } if_id_t;

  localparam if_id_t D_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    ra:    REG_NONE,
    rb:    REG_NONE,
    valc:  64'd0,
    valp:  64'd0
  };

  function automatic logic has_regids(input logic [3:0] ic);
    return ic inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ,
                      I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
  endfunction

  function automatic logic has_valc(input logic [3:0] ic);
    return ic inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                      I_JXX, I_CALL};
  endfunction

endpackage

// File: rtl/fetch_split.sv
// Splits the fetched bytes into icode/ifun/rA/rB/valC.
// In: byte0, byte19, imem_err. Out: fields, need_*, valid.
module fetch_split
  import y86_pkg::*;
(
  input  logic [7:0]  byte0,
  input  logic [71:0] byte19,
  input  logic        imem_err,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valc,
  output logic        need_regids,
  output logic        need_valc,
  output logic        instr_valid
);

  logic [7:0]  b0;
  logic [71:0] b19;
  logic [63:0] win;

  // A bad fetch address decodes as all-zero bytes (halt).
  assign b0  = imem_err ? 8'h00 : byte0;
  assign b19 = imem_err ? 72'h0 : byte19;

  assign icode       = b0[7:4];
  assign ifun        = b0[3:0];
  assign need_regids = has_regids(icode);
  assign need_valc   = has_valc(icode);

  assign ra = need_regids ? b19[71:68] : REG_NONE;
  assign rb = need_regids ? b19[67:64] : REG_NONE;

  // Constant starts after the register byte when present;
  // memory order is little-endian, so byte-reverse it.
  assign win = need_regids ? b19[63:0] : b19[71:8];

  always_comb begin
    valc = '0;
    for (int k = 0; k < 8; k++) begin
      if (need_valc) valc[8*k +: 8] = win[63-8*k -: 8];
    end
  end

  always_comb begin
    instr_valid = 1'b0;
    unique case (1'b1)
      (icode > I_POPQ):
        instr_valid = 1'b0;
      (icode == I_OPQ):
        instr_valid = (ifun <= 4'd3);
      (icode == I_JXX || icode == I_RRMOVQ):
        instr_valid = (ifun <= 4'd6);
      default:
        instr_valid = (ifun == 4'd0);
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch: PC select, split, valP/predPC, F and D regs.
// Drives pc_o to imem; registers fields into D for decode.
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc_o,
  input  logic [7:0]  byte0,
  input  logic [71:0] byte19,
  input  logic        imem_err,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP
);

  logic [63:0] f_predpc;
  logic [63:0] pred_pc;
  logic [63:0] valp;
  logic [63:0] valc;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic        need_regids;
  logic        need_valc;
  logic        instr_valid;
  logic [2:0]  stat;
  if_id_t      f_out;
  if_id_t      d_q;

  // Not-taken jump in M beats a ret in W.
  always_comb begin
    pc_o = f_predpc;
    unique case (1'b1)
      (M_icode == I_JXX && !M_Cnd):
        pc_o = M_valA;
      (!(M_icode == I_JXX && !M_Cnd) && W_icode == I_RET):
        pc_o = W_valM;
      default:
        pc_o = f_predpc;
    endcase
  end

  fetch_split u_split (
    .byte0       (byte0),
    .byte19      (byte19),
    .imem_err    (imem_err),
    .icode       (icode),
    .ifun        (ifun),
    .ra          (ra),
    .rb          (rb),
    .valc        (valc),
    .need_regids (need_regids),
    .need_valc   (need_valc),
    .instr_valid (instr_valid)
  );

  assign valp = pc_o + 64'd1
              + {63'd0, need_regids}
              + {60'd0, need_valc, 3'b000};

  assign pred_pc = (icode == I_JXX || icode == I_CALL)
                 ? valc : valp;

  always_comb begin
    stat = STAT_AOK;
    unique case (1'b1)
      imem_err:
        stat = STAT_ADR;
      (!imem_err && !instr_valid):
        stat = STAT_INS;
      (!imem_err && instr_valid && icode == I_HALT):
        stat = STAT_HLT;
      default:
        stat = STAT_AOK;
    endcase
  end

  assign f_out = '{
    stat:  stat,
    icode: icode,
    ifun:  ifun,
    ra:    ra,
    rb:    rb,
    valc:  valc,
    valp:  valp
  };

  // Fetch freezes once a non-AOK instruction is seen,
  // until a redirect from M/W or a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_predpc <= RESET_PC;
    end else if (!F_stall && stat == STAT_AOK) begin
      f_predpc <= pred_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= D_BUBBLE;
    end else if (D_stall) begin
      d_q <= d_q;
    end else if (D_bubble) begin
      d_q <= D_BUBBLE;
    end else begin
      d_q <= f_out;
    end
  end

  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_rA    = d_q.ra;
  assign D_rB    = d_q.rb;
  assign D_valC  = d_q.valc;
  assign D_valP  = d_q.valp;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: byte-array memory,
// byte-level reference fetch model, queued D checks.
module tb_fetch_stage;

  localparam int          MEMSZ    = 512;
  localparam logic [63:0] IMEM_LIM = 64'd256;
  localparam logic [63:0] RST_PC   = 64'd0;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } dreg_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pc_o;
  logic [7:0]  byte0;
  logic [71:0] byte19;
  logic        imem_err;
  logic        F_stall = 1'b0;
  logic        D_stall = 1'b0;
  logic        D_bubble = 1'b0;
  logic [3:0]  M_icode = 4'h0;
  logic        M_Cnd = 1'b0;
  logic [63:0] M_valA = 64'd0;
  logic [3:0]  W_icode = 4'h0;
  logic [63:0] W_valM = 64'd0;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode;
  logic [3:0]  D_ifun;
  logic [3:0]  D_rA;
  logic [3:0]  D_rB;
  logic [63:0] D_valC;
  logic [63:0] D_valP;

  logic [7:0]  mem [MEMSZ];
  dreg_t       exp_q [$];
  dreg_t       m_d;
  logic [63:0] m_pred = 64'd0;
  bit          m_known = 1'b0;
  int          nvec = 0;
  int          nbad = 0;
  dreg_t       bub;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_o     (pc_o),
    .byte0    (byte0),
    .byte19   (byte19),
    .imem_err (imem_err),
    .F_stall  (F_stall),
    .D_stall  (D_stall),
    .D_bubble (D_bubble),
    .M_icode  (M_icode),
    .M_Cnd    (M_Cnd),
    .M_valA   (M_valA),
    .W_icode  (W_icode),
    .W_valM   (W_valM),
    .D_stat   (D_stat),
    .D_icode  (D_icode),
    .D_ifun   (D_ifun),
    .D_rA     (D_rA),
    .D_rB     (D_rB),
    .D_valC   (D_valC),
    .D_valP   (D_valP)
  );

  // Beyond MEMSZ the memory returns garbage; the DUT must
  // ignore it because imem_err is raised there.
  function automatic logic [7:0] rd(input logic [63:0] a);
    if (a < 64'(MEMSZ)) return mem[a[8:0]];
    return 8'hAA;
  endfunction

  always_comb begin
    byte0  = rd(pc_o);
    byte19 = '0;
    for (int k = 1; k <= 9; k++)
      byte19[8*(9-k) +: 8] = rd(pc_o + 64'(k));
    imem_err = (pc_o >= IMEM_LIM);
  end

  function automatic logic [7:0] fb(input logic [63:0] a,
                                    input bit err);
    return err ? 8'h00 : rd(a);
  endfunction

  // Reference fetch, computed straight from instruction bytes.
  function automatic void model_fetch(input logic [63:0] pc,
                                      output dreg_t d,
                                      output logic [63:0] pred);
    bit          err;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          ic;
    int          fn;
    bit          regs;
    bit          cw;
    bit          ok;
    logic [63:0] c;
    err  = (pc >= IMEM_LIM);
    b0   = fb(pc, err);
    b1   = fb(pc + 64'd1, err);
    ic   = int'(b0[7:4]);
    fn   = int'(b0[3:0]);
    regs = ic inside {2, 3, 4, 5, 6, 10, 11};
    cw   = ic inside {3, 4, 5, 7, 8};
    c    = 64'd0;
    if (cw)
      for (int k = 0; k < 8; k++)
        c[8*k +: 8] = fb(pc + 64'(1 + int'(regs) + k), err);
    ok = (ic <= 11) && (fn == 0 || (ic == 6 && fn <= 3)
         || ((ic == 2 || ic == 7) && fn <= 6));
    d.stat  = err ? 3'd3 : !ok ? 3'd4 : (ic == 0) ? 3'd2 : 3'd1;
    d.icode = b0[7:4];
    d.ifun  = b0[3:0];
    d.ra    = regs ? b1[7:4] : 4'hF;
    d.rb    = regs ? b1[3:0] : 4'hF;
    d.valc  = c;
    d.valp  = pc + 64'd1 + 64'(regs) + 64'(cw) * 64'd8;
    pred    = (ic == 7 || ic == 8) ? c : d.valp;
  endfunction

  task automatic cyc(input bit r, input bit fs, input bit ds,
                     input bit db, input logic [3:0] mi,
                     input bit mc, input logic [63:0] mva,
                     input logic [3:0] wi,
                     input logic [63:0] wvm);
    logic [63:0] epc;
    logic [63:0] pred;
    dreg_t       f;
    @(negedge clk);
    rst = r; F_stall = fs; D_stall = ds; D_bubble = db;
    M_icode = mi; M_Cnd = mc; M_valA = mva;
    W_icode = wi; W_valM = wvm;
    #1;
    if (mi == 4'd7 && !mc)  epc = mva;
    else if (wi == 4'd9)    epc = wvm;
    else                    epc = m_pred;
    if (m_known) begin
      nvec++;
      if (pc_o !== epc) begin
        nbad++;
        $display("FAIL pc_o got %h want %h", pc_o, epc);
      end
    end
    model_fetch(epc, f, pred);
    if (r)        m_d = bub;
    else if (ds)  m_d = m_d;
    else if (db)  m_d = bub;
    else          m_d = f;
    if (m_known || r) exp_q.push_back(m_d);
    if (r)                       m_pred = RST_PC;
    else if (!fs && f.stat == 1) m_pred = pred;
    if (r) m_known = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 0, 4'h0, 0, 64'd0, 4'h0, 64'd0);
  endtask

  task automatic put(input int a, input logic [79:0] b,
                     input int n);
    logic [79:0] v;
    v = b;
    for (int k = 0; k < n; k++)
      mem[a+k] = v[79-8*k -: 8];
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] ops [21];
    ops = '{8'h10, 8'h20, 8'h23, 8'h30, 8'h40, 8'h50,
            8'h60, 8'h61, 8'h63, 8'h70, 8'h71, 8'h76,
            8'h80, 8'h90, 8'hA0, 8'hB0, 8'h00, 8'h64,
            8'h27, 8'h11, 8'hC0};
    if ($urandom_range(0, 9) < 6)
      return ops[$urandom_range(0, 20)];
    return 8'($urandom);
  endfunction

  // Monitor: each cycle the DUT's D register is due, pop and compare.
  initial begin
    dreg_t e;
    dreg_t g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{stat: D_stat, icode: D_icode, ifun: D_ifun,
              ra: D_rA, rb: D_rB, valc: D_valC, valp: D_valP};
        nvec++;
        if (g !== e) begin
          nbad++;
          $display("FAIL d_reg got st%0d ic%h fn%h ra%h rb%h c%h p%h want st%0d ic%h fn%h ra%h rb%h c%h p%h",
                   g.stat, g.icode, g.ifun, g.ra, g.rb, g.valc, g.valp,
                   e.stat, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bub = '{stat: 3'd1, icode: 4'd1, ifun: 4'd0, ra: 4'hF,
            rb: 4'hF, valc: 64'd0, valp: 64'd0};
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h10;
    for (int i = 100; i < MEMSZ; i++) mem[i] = rnd_byte();
    put(0,  80'h30FB0500000000000000, 10);
    put(10, 80'h70140000000000000000, 9);
    put(20, 80'h60BA0000000000000000, 2);
    put(26, 80'h75260000000000000000, 9);
    mem[38] = 8'hC0;
    mem[64] = 8'h00;

    cyc(1, 0, 0, 0, 4'h0, 0, 64'd0, 4'h0, 64'd0);
    cyc(1, 0, 0, 0, 4'h0, 0, 64'd0, 4'h0, 64'd0);
    run(11);
    cyc(0, 0, 0, 0, 4'h7, 0, 64'h40, 4'h9, 64'h99);
    run(2);
    cyc(0, 0, 0, 0, 4'h0, 0, 64'd0, 4'h9, 64'd0);
    cyc(0, 1, 1, 1, 4'h0, 0, 64'd0, 4'h0, 64'd0);
    cyc(0, 1, 1, 1, 4'h0, 0, 64'd0, 4'h0, 64'd0);
    run(1);
    cyc(0, 0, 0, 0, 4'h7, 1, 64'h40, 4'h0, 64'd0);
    cyc(0, 0, 0, 1, 4'h0, 0, 64'd0, 4'h0, 64'd0);
    cyc(0, 0, 0, 0, 4'h0, 0, 64'd0, 4'h9, 64'd300);
    run(2);
    cyc(0, 0, 0, 0, 4'h0, 0, 64'd0, 4'h9, '1);
    cyc(0, 0, 0, 0, 4'h0, 0, 64'd0, 4'h9, 64'd10);
    run(2);
    cyc(1, 1, 1, 1, 4'h7, 0, 64'h40, 4'h9, 64'h20);
    run(3);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  mi;
      logic [3:0]  wi;
      logic [63:0] mva;
      logic [63:0] wvm;
      mi  = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom);
      wi  = ($urandom_range(0, 7) == 0) ? 4'h9 : 4'($urandom);
      mva = 64'($urandom_range(0, 320));
      wvm = ($urandom_range(0, 19) == 0)
          ? {32'($urandom), 32'($urandom)}
          : 64'($urandom_range(0, 320));
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0,
          mi, 1'($urandom), mva, wi, wvm);
    end

    @(negedge clk);
    @(negedge clk);
    nvec++;
    if (exp_q.size() != 0) begin
      nbad++;
      $display("FAIL drain got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
